serv_rf_bridge: RTL and testbench



---
 rtl/serv_rf_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_serv_rf_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_rf_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serv_rf_bridge
// Description : Bit-serial register-file bridge between the SERV control stage
//               and a 1R/1W synchronous SRAM holding x0..x31 plus CSR backing.
// Revision    : 1.0 - initial release
// ============================================================================
module serv_rf_bridge #(
    parameter int RAM_W    = 8,
    parameter int CSR_REGS = 4,
    localparam int WPR     = 32 / RAM_W,
    localparam int DEPTH   = (32 + CSR_REGS) * WPR,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rreq,
    input  logic             i_wreq,
    output logic             o_ready,
    input  logic [5:0]       i_rreg0,
    input  logic [5:0]       i_rreg1,
    input  logic [5:0]       i_wreg0,
    input  logic             i_wen0,
    input  logic             i_wdata0,
    output logic             o_rdata0,
    output logic             o_rdata1,
    output logic [AW-1:0]    o_raddr,
    output logic             o_ren,
    input  logic [RAM_W-1:0] i_rdata,
    output logic [AW-1:0]    o_waddr,
    output logic [RAM_W-1:0] o_wdata,
    output logic             o_wen
);

    localparam int         LW        = $clog2(RAM_W);
    localparam logic [4:0] C_LO_MASK = 5'(RAM_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RPRE   = 3'd1,
        S_RRUN   = 3'd2,
        S_WRUN   = 3'd3,
        S_WFLUSH = 3'd4
    } state_t;

    state_t           r_state;
    logic [4:0]       r_cnt;
    logic [1:0]       r_pre;
    logic [5:0]       r_rreg0;
    logic [5:0]       r_rreg1;
    logic [5:0]       r_wreg0;
    logic             r_wen0;
    logic [RAM_W-1:0] r_hold;
    logic [RAM_W-1:0] r_sh0;
    logic [RAM_W-1:0] r_sh1;
    logic [RAM_W-1:0] r_asm;

    logic [4:0]       w_cnt_nxt;
    logic [4:0]       w_lo;
    logic [4:0]       w_lo_nxt;
    logic [4:0]       w_word;
    logic [4:0]       w_word_nxt;
    logic             w_more;
    logic             w_more_nxt;
    logic [RAM_W-1:0] w_asm_nxt;
    logic             w_wr_ok;

    function automatic logic [AW-1:0] addr_of(input logic [5:0] r, input logic [4:0] w);
        return AW'(32'(r) * 32'(WPR) + 32'(w));
    endfunction

    // w_more*: the word (current / upcoming) still has a successor to refill.
    always_comb begin
        w_cnt_nxt  = r_cnt + 5'd1;
        w_lo       = r_cnt & C_LO_MASK;
        w_lo_nxt   = w_cnt_nxt & C_LO_MASK;
        w_word     = r_cnt >> LW;
        w_word_nxt = w_cnt_nxt >> LW;
        w_more     = int'(w_word) < (WPR - 1);
        w_more_nxt = int'(w_word_nxt) < (WPR - 1);
        w_asm_nxt  = {i_wdata0, r_asm[RAM_W-1:1]};
        w_wr_ok    = r_wen0 && (r_wreg0 != 6'd0);
    end

    assign o_rdata0 = r_sh0[0];
    assign o_rdata1 = r_sh1[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_pre   <= 2'd0;
            r_rreg0 <= 6'd0;
            r_rreg1 <= 6'd0;
            r_wreg0 <= 6'd0;
            r_wen0  <= 1'b0;
            r_hold  <= '0;
            r_sh0   <= '0;
            r_sh1   <= '0;
            r_asm   <= '0;
            o_ready <= 1'b0;
            o_ren   <= 1'b0;
            o_raddr <= '0;
            o_wen   <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
        end else begin
            o_ready <= 1'b0;
            o_ren   <= 1'b0;
            o_wen   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 5'd0;
                    if (i_rreq) begin
                        r_state <= S_RPRE;
                        r_pre   <= 2'd0;
                        r_rreg0 <= i_rreg0;
                        r_rreg1 <= i_rreg1;
                        o_ren   <= 1'b1;
                        o_raddr <= addr_of(i_rreg0, 5'd0);
                    end else if (i_wreq) begin
                        r_state <= S_WRUN;
                        r_wreg0 <= i_wreg0;
                        r_wen0  <= i_wen0;
                        o_ready <= 1'b1;
                    end
                end

                S_RPRE: begin
                    r_pre <= r_pre + 2'd1;
                    case (r_pre)
                        2'd0: begin
                            o_ren   <= 1'b1;
                            o_raddr <= addr_of(r_rreg1, 5'd0);
                        end
                        2'd1: begin
                            r_hold  <= i_rdata;
                            o_ready <= 1'b1;
                        end
                        default: begin
                            // x0 is forced to zero by loading zeros, not by masking.
                            r_sh0   <= (r_rreg0 != 6'd0) ? r_hold  : '0;
                            r_sh1   <= (r_rreg1 != 6'd0) ? i_rdata : '0;
                            r_cnt   <= 5'd0;
                            r_state <= S_RRUN;
                        end
                    endcase
                end

                S_RRUN: begin
                    r_cnt <= w_cnt_nxt;
                    if (int'(w_lo_nxt) == RAM_W - 3 && w_more_nxt) begin
                        o_ren   <= 1'b1;
                        o_raddr <= addr_of(r_rreg0, w_word_nxt + 5'd1);
                    end else if (int'(w_lo_nxt) == RAM_W - 2 && w_more_nxt) begin
                        o_ren   <= 1'b1;
                        o_raddr <= addr_of(r_rreg1, w_word_nxt + 5'd1);
                    end
                    if (int'(w_lo) == RAM_W - 2 && w_more) begin
                        r_hold <= i_rdata;
                    end
                    if (int'(w_lo) == RAM_W - 1 && w_more) begin
                        r_sh0 <= (r_rreg0 != 6'd0) ? r_hold  : '0;
                        r_sh1 <= (r_rreg1 != 6'd0) ? i_rdata : '0;
                    end else begin
                        r_sh0 <= {1'b0, r_sh0[RAM_W-1:1]};
                        r_sh1 <= {1'b0, r_sh1[RAM_W-1:1]};
                    end
                    if (r_cnt == 5'd31) begin
                        r_state <= S_IDLE;
                    end
                end

                S_WRUN: begin
                    // The first WRUN cycle is the ready pulse; bits start after it.
                    if (!o_ready) begin
                        r_cnt <= w_cnt_nxt;
                        r_asm <= w_asm_nxt;
                        if (w_lo == C_LO_MASK) begin
                            o_wen   <= w_wr_ok;
                            o_waddr <= addr_of(r_wreg0, w_word);
                            o_wdata <= w_asm_nxt;
                        end
                        if (r_cnt == 5'd31) begin
                            r_state <= S_WFLUSH;
                        end
                    end
                end

                S_WFLUSH: begin
                    r_cnt   <= 5'd0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serv_rf_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serv_rf_bridge
// Description : Self-checking bench for serv_rf_bridge with an SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serv_rf_bridge;

    localparam int RAM_W    = 8;
    localparam int CSR_REGS = 4;
    localparam int WPR      = 32 / RAM_W;
    localparam int DEPTH    = (32 + CSR_REGS) * WPR;
    localparam int AW       = $clog2(DEPTH);

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_rreq = 1'b0;
    logic             i_wreq = 1'b0;
    logic             o_ready;
    logic [5:0]       i_rreg0 = '0;
    logic [5:0]       i_rreg1 = '0;
    logic [5:0]       i_wreg0 = '0;
    logic             i_wen0 = 1'b0;
    logic             i_wdata0 = 1'b0;
    logic             o_rdata0;
    logic             o_rdata1;
    logic [AW-1:0]    o_raddr;
    logic             o_ren;
    logic [RAM_W-1:0] i_rdata = '0;
    logic [AW-1:0]    o_waddr;
    logic [RAM_W-1:0] o_wdata;
    logic             o_wen;

    serv_rf_bridge #(.RAM_W(RAM_W), .CSR_REGS(CSR_REGS)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rreq(i_rreq), .i_wreq(i_wreq),
        .o_ready(o_ready), .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
        .i_wreg0(i_wreg0), .i_wen0(i_wen0), .i_wdata0(i_wdata0),
        .o_rdata0(o_rdata0), .o_rdata1(o_rdata1), .o_raddr(o_raddr),
        .o_ren(o_ren), .i_rdata(i_rdata), .o_waddr(o_waddr),
        .o_wdata(o_wdata), .o_wen(o_wen)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { int addr; int data; int cyc; } ev_t;
    typedef struct { logic [5:0] wreg; logic [31:0] wval; bit wen; logic [31:0] rd_exp; } vec_t;

    ev_t              q_ren[$];
    ev_t              q_wr[$];
    logic [63:0]      q_rd[$];
    logic [RAM_W-1:0] mem     [DEPTH];
    logic [RAM_W-1:0] ref_mem [DEPTH];
    bit               loaded = 1'b0;
    int               cyc = 0;
    int               ren_cnt = 0;
    int               wen_cnt = 0;
    int               n_checks = 0;
    int               n_pass = 0;

    function automatic logic [31:0] init_reg(input int r);
        case (r)
            0:       return 32'hFFFF_0000;
            5:       return 32'hA5A5_1234;
            7:       return 32'h0F0F_00FF;
            default: return {8{4'(r)}};
        endcase
    endfunction

    function automatic logic [RAM_W-1:0] init_word(input int i);
        logic [31:0] v;
        v = init_reg(i / WPR);
        return v[(i % WPR)*RAM_W +: RAM_W];
    endfunction

    function automatic int addr(input int r, input int w);
        return r * WPR + w;
    endfunction

    function automatic logic [31:0] reg_val(input int r);
        logic [31:0] v;
        v = '0;
        for (int w = 0; w < WPR; w++) v[w*RAM_W +: RAM_W] = ref_mem[addr(r, w)];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency, write on strobe.
    always @(posedge i_clk) begin
        if (!loaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (o_wen) begin
            mem[o_waddr] <= o_wdata;
        end
        if (o_ren) i_rdata <= mem[o_raddr];
    end

    // Scoreboard monitor for SRAM strobes.
    always @(negedge i_clk) begin
        ev_t e;
        if (o_ren === 1'b1) begin
            ren_cnt++;
            if (q_ren.size() == 0) chk("ren_unexpected", 64'(o_ren), 64'd0);
            else begin
                e = q_ren.pop_front();
                chk("ren_addr", 64'(o_raddr), 64'(e.addr));
                chk("ren_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (o_wen === 1'b1) begin
            wen_cnt++;
            if (q_wr.size() == 0) chk("wen_unexpected", 64'(o_wen), 64'd0);
            else begin
                e = q_wr.pop_front();
                chk("wen_addr", 64'(o_waddr), 64'(e.addr));
                chk("wen_data", 64'(o_wdata), 64'(e.data));
                chk("wen_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic do_read(input logic [5:0] r0, input logic [5:0] r1, input bit collide,
                           output logic [31:0] got0, output logic [31:0] got1);
        logic [31:0] e0, e1;
        logic [63:0] exp;
        ev_t         ev;
        int          t0, nrdy, trdy;
        e0 = (r0 == 6'd0) ? 32'd0 : reg_val(r0);
        e1 = (r1 == 6'd0) ? 32'd0 : reg_val(r1);
        q_rd.push_back({e0, e1});
        @(negedge i_clk);
        t0 = cyc;
        for (int w = 0; w < WPR; w++) begin
            ev.data = 0;
            ev.addr = addr(r0, w);
            ev.cyc  = (w == 0) ? t0 + 1 : t0 + 4 + (w - 1)*RAM_W + RAM_W - 3;
            q_ren.push_back(ev);
            ev.addr = addr(r1, w);
            ev.cyc  = ev.cyc + 1;
            q_ren.push_back(ev);
        end
        ren_cnt = 0;
        i_rreq = 1'b1; i_rreg0 = r0; i_rreg1 = r1;
        i_wreq = collide; i_wreg0 = 6'd9; i_wen0 = 1'b1;
        @(negedge i_clk);
        i_rreq = 1'b0; i_wreq = 1'b0;
        nrdy = 0; trdy = 0; got0 = '0; got1 = '0;
        for (int t = 1; t <= 35; t++) begin
            if (o_ready === 1'b1) begin nrdy++; trdy = t; end
            if (t == 1 || t == 2) chk((t == 1) ? "ren_T1" : "ren_T2", 64'(o_ren), 64'd1);
            if (t >= 4) begin got0[t-4] = o_rdata0; got1[t-4] = o_rdata1; end
            if (collide && t == 10) i_wreq = 1'b1;
            if (collide && t == 11) i_wreq = 1'b0;
            @(negedge i_clk);
        end
        chk("ready_pulse", {32'(nrdy), 32'(trdy)}, {32'd1, 32'd3});
        exp = q_rd.pop_front();
        chk("rdata", {got0, got1}, exp);
        repeat (3) @(negedge i_clk);
        chk("ren_count", 64'(ren_cnt), 64'(2*WPR));
        chk("ren_queue_empty", 64'(q_ren.size()), 64'd0);
    endtask

    task automatic do_write(input logic [5:0] r, input logic [31:0] v, input bit en, input int abort_b);
        ev_t ev;
        int  t0, nw;
        bit  aborted;
        @(negedge i_clk);
        t0 = cyc;
        nw = 0;
        for (int k = 0; k < WPR; k++) begin
            if (en && r != 6'd0 && (abort_b < 0 || (k+1)*RAM_W - 1 < abort_b)) begin
                ev.addr = addr(r, k);
                ev.data = int'(v[k*RAM_W +: RAM_W]);
                ev.cyc  = t0 + 2 + (k+1)*RAM_W;
                q_wr.push_back(ev);
                ref_mem[ev.addr] = v[k*RAM_W +: RAM_W];
                nw++;
            end
        end
        wen_cnt = 0;
        i_wreq = 1'b1; i_wreg0 = r; i_wen0 = en;
        @(negedge i_clk);
        i_wreq = 1'b0;
        chk("ready_T1", 64'(o_ready), 64'd1);
        aborted = 1'b0;
        for (int b = 0; b < 32 && !aborted; b++) begin
            @(negedge i_clk);
            if (b == 0) chk("ready_T2", 64'(o_ready), 64'd0);
            if (b == abort_b) begin
                i_rst = 1'b1;
                aborted = 1'b1;
            end else begin
                i_wdata0 = v[b];
            end
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("wen_count", 64'(wen_cnt), 64'(nw));
        chk("wr_queue_empty", 64'(q_wr.size()), 64'd0);
    endtask

    vec_t        tbl [5];
    logic [31:0] g0, g1;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        tbl[0] = '{wreg: 6'd3,  wval: 32'hDEAD_BEEF, wen: 1'b1, rd_exp: 32'hDEAD_BEEF};
        tbl[1] = '{wreg: 6'd0,  wval: 32'hFFFF_FFFF, wen: 1'b1, rd_exp: 32'h0000_0000};
        tbl[2] = '{wreg: 6'd9,  wval: 32'h1234_5678, wen: 1'b0, rd_exp: 32'h9999_9999};
        tbl[3] = '{wreg: 6'd33, wval: 32'hCAFE_F00D, wen: 1'b1, rd_exp: 32'hCAFE_F00D};
        tbl[4] = '{wreg: 6'd31, wval: 32'h8000_0001, wen: 1'b1, rd_exp: 32'h8000_0001};

        // Reset held three cycles with requests pulsed.
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("reset_outputs", 64'({o_ready, o_ren, o_wen, o_rdata0, o_rdata1,
                                      o_raddr, o_waddr, o_wdata}), 64'd0);
            i_rreq = 1'b1; i_wreq = 1'b1;
        end
        i_rst = 1'b0; i_rreq = 1'b0; i_wreq = 1'b0;

        do_read(6'd5, 6'd7, 1'b0, g0, g1);
        chk("x5_value", 64'(g0), 64'h0000_0000_A5A5_1234);
        chk("x7_value", 64'(g1), 64'h0000_0000_0F0F_00FF);

        for (int i = 0; i < 5; i++) begin
            do_write(tbl[i].wreg, tbl[i].wval, tbl[i].wen, -1);
            do_read(tbl[i].wreg, 6'd7, 1'b0, g0, g1);
            chk("tbl_readback", 64'(g0), 64'(tbl[i].rd_exp));
        end

        do_read(6'd0, 6'd0, 1'b0, g0, g1);
        chk("x0_read", {g0, g1}, 64'd0);

        // Collision with a simultaneous and a mid-read write request.
        do_read(6'd33, 6'd5, 1'b1, g0, g1);
        chk("csr33_read", 64'(g0), 64'h0000_0000_CAFE_F00D);

        // Reset during bit 12 of a write to x2.
        do_write(6'd2, 32'h1357_9BDF, 1'b1, 12);
        chk("abort_word2", 64'(mem[addr(2, 2)]), 64'(ref_mem[addr(2, 2)]));
        chk("abort_word3", 64'(mem[addr(2, 3)]), 64'(ref_mem[addr(2, 3)]));
        do_read(6'd2, 6'd2, 1'b0, g0, g1);
        chk("abort_readback", 64'(g0), 64'h0000_0000_2222_22DF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
